// File: rtl/scc_fetch_unit.sv
// scc_fetch_unit
//   Instruction fetch stage in front of the single-cycle core. It holds the
//   fetch PC as a 62-bit word index and issues reads to a 1-cycle-latency
//   instruction memory. Returned words are buffered in a small FIFO and
//   handed to the core through a valid/ready interface. A redirect flushes
//   the FIFO, drops the in-flight read and restarts fetch at redirect_pc.
//
// Ports
//   clk, rst         core clock, synchronous active-low reset
//   clk_en           clock enable; all state holds while low
//   redirect_valid   load fetch PC from redirect_pc and flush
//   redirect_pc      new fetch word index
//   imem_a/imem_en   instruction memory byte address / read enable
//   imem_rdata       read data, valid the cycle after imem_en
//   out_valid/ready  handshake toward the core
//   out_instr/out_pc FIFO head word and its word index (0 when empty)
//   perf_stall_cnt   (FETCH_PERF_EN only) saturating count of cycles
//                    where issue was blocked by a full buffer
//
// Build option
//   FETCH_PERF_EN    adds perf_stall_cnt output and its counter
//
// state  | meaning
// S_BOOT | first enabled cycle after reset, nothing issued
// S_RUN  | normal fetch; left only through reset

module scc_fetch_unit #(
    parameter logic [61:0] RESET_PC   = 62'd0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        redirect_valid,
    input  logic [61:0] redirect_pc,
    output logic [31:0] imem_a,
    output logic        imem_en,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [61:0] out_pc,
    input  logic        out_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W+1:0] DEPTH_W = (PTR_W+2)'(FIFO_DEPTH);

    typedef enum logic {
        S_BOOT,
        S_RUN
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [61:0]    fetch_pc;
    logic           inflight;
    logic [61:0]    inflight_pc;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0] count;
    logic [PTR_W+1:0] occupancy;
    logic           credit_ok;
    logic           fifo_nonempty;

    logic           issue;
    logic           push;
    logic           pop;
    logic           flush;

    logic [31:0]    instr_mem [FIFO_DEPTH];
    logic [61:0]    pc_mem    [FIFO_DEPTH];

    // The in-flight read already holds a slot, so it counts against the
    // buffer; a pop in the same cycle frees nothing until the next cycle.
    assign occupancy     = {1'b0, count} + {{(PTR_W+1){1'b0}}, inflight};
    assign credit_ok     = occupancy < DEPTH_W;
    assign fifo_nonempty = (count != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        case (state_q)
            S_BOOT: begin
                if (clk_en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (clk_en) begin
                    if (redirect_valid) begin
                        // Not pushing and clearing inflight is what kills
                        // the response currently on imem_rdata.
                        flush = 1'b1;
                    end else begin
                        push  = inflight;
                        pop   = fifo_nonempty & out_ready;
                        issue = credit_ok;
                    end
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else if (clk_en) begin
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 62'd1;
            end
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + (PTR_W+1)'(1);
                end else if (pop && !push) begin
                    count <= count - (PTR_W+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]    <= inflight_pc;
        end
    end

    assign imem_a    = {fetch_pc[29:0], 2'b00};
    assign imem_en   = issue & rst;
    assign out_valid = fifo_nonempty & rst;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : 32'd0;
    assign out_pc    = out_valid ? pc_mem[rd_ptr] : 62'd0;

`ifdef FETCH_PERF_EN
    logic perf_stall;

    assign perf_stall = (state_q == S_RUN) & clk_en & ~redirect_valid & ~credit_ok;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_cnt <= 32'd0;
        end else if (perf_stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_scc_fetch_unit.sv
module tb_scc_fetch_unit;

    localparam logic [61:0] RPC = 62'h100;
    localparam logic [31:0] TAG = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [61:0] redirect_pc = '0;
    logic [31:0] imem_a;
    logic        imem_en;
    logic [31:0] imem_rdata = 32'd0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [61:0] out_pc;
    logic        out_ready = 1'b0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scc_fetch_unit #(
        .RESET_PC  (RPC),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_a        (imem_a),
        .imem_en       (imem_en),
        .imem_rdata    (imem_rdata),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_ready     (out_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // Instruction memory: 1-cycle latency, holds data when not enabled,
    // each word tagged with its own byte address.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_a ^ TAG;
    end

    function automatic logic [31:0] exp_instr(input logic [61:0] pc);
        return {pc[29:0], 2'b00} ^ TAG;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    // Returns positioned in the first cycle after reset release (S_BOOT).
    task automatic reset_start(input logic rdy);
        tick;
        rst = 1'b0; clk_en = 1'b1; redirect_valid = 1'b0; out_ready = rdy;
        tick;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0; clk_en = 1'b1; out_ready = 1'b1;
        tick;
        sample;
        checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL reset_imem_en got %0b want 0", imem_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out_instr !== 32'd0) begin errors++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
        checks++; if (out_pc !== 62'd0) begin errors++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
        tick;
        clk_en = 1'b0;
        sample;
        checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL reset_gated_imem_en got %0b want 0", imem_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_gated_out_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_stream;
        reset_start(1'b1);
        sample;
        checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL stream_boot_imem_en got %0b want 0", imem_en); end
        for (int c = 1; c <= 8; c++) begin
            tick;
            sample;
            checks++; if (imem_en !== 1'b1 || imem_a !== 32'h400 + 32'(4 * (c - 1)))
                begin errors++; $display("FAIL stream_issue c%0d got en=%0b a=%h want en=1 a=%h", c, imem_en, imem_a, 32'h400 + 32'(4 * (c - 1))); end
            checks++; if (out_valid !== (c >= 3))
                begin errors++; $display("FAIL stream_valid c%0d got %0b want %0b", c, out_valid, (c >= 3)); end
            if (c >= 3) begin
                checks++; if (out_pc !== RPC + 62'(c - 3) || out_instr !== exp_instr(RPC + 62'(c - 3)))
                    begin errors++; $display("FAIL stream_head c%0d got pc=%h instr=%h want pc=%h instr=%h", c, out_pc, out_instr, RPC + 62'(c - 3), exp_instr(RPC + 62'(c - 3))); end
            end
        end
    endtask

    task automatic test_fill;
        int n_issue;
        n_issue = 0;
        reset_start(1'b0);
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) tick;
            sample;
            if (imem_en === 1'b1) n_issue++;
        end
        checks++; if (n_issue != 4) begin errors++; $display("FAIL fill_issue_count got %0d want 4", n_issue); end
        checks++; if (out_valid !== 1'b1 || out_pc !== RPC)
            begin errors++; $display("FAIL fill_head got v=%0b pc=%h want v=1 pc=%h", out_valid, out_pc, RPC); end
        tick;
        out_ready = 1'b1;
        sample;
        checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL fill_pop_not_credited got %0b want 0", imem_en); end
        checks++; if (out_pc !== RPC) begin errors++; $display("FAIL fill_pop0 got %h want %h", out_pc, RPC); end
        tick;
        sample;
        checks++; if (imem_en !== 1'b1 || imem_a !== 32'h410)
            begin errors++; $display("FAIL fill_resume got en=%0b a=%h want en=1 a=410", imem_en, imem_a); end
        checks++; if (out_pc !== RPC + 62'd1) begin errors++; $display("FAIL fill_pop1 got %h want %h", out_pc, RPC + 62'd1); end
        for (int k = 2; k <= 4; k++) begin
            tick;
            sample;
            checks++; if (out_valid !== 1'b1 || out_pc !== RPC + 62'(k))
                begin errors++; $display("FAIL fill_drain k%0d got v=%0b pc=%h want v=1 pc=%h", k, out_valid, out_pc, RPC + 62'(k)); end
        end
    endtask

    task automatic test_redirect;
        reset_start(1'b0);
        for (int c = 1; c <= 3; c++) tick;
        tick;
        redirect_valid = 1'b1; redirect_pc = 62'h2000;
        sample;
        checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL redir_imem_en got %0b want 0", imem_en); end
        checks++; if (out_valid !== 1'b1 || out_pc !== RPC)
            begin errors++; $display("FAIL redir_pre_head got v=%0b pc=%h want v=1 pc=%h", out_valid, out_pc, RPC); end
        tick;
        redirect_valid = 1'b0;
        sample;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %0b want 0", out_valid); end
        checks++; if (imem_en !== 1'b1 || imem_a !== 32'h8000)
            begin errors++; $display("FAIL redir_first_issue got en=%0b a=%h want en=1 a=8000", imem_en, imem_a); end
        tick;
        sample;
        checks++; if (out_valid !== 1'b0 || imem_a !== 32'h8004)
            begin errors++; $display("FAIL redir_kill got v=%0b a=%h want v=0 a=8004", out_valid, imem_a); end
        tick;
        out_ready = 1'b1;
        sample;
        checks++; if (out_valid !== 1'b1 || out_pc !== 62'h2000 || out_instr !== exp_instr(62'h2000))
            begin errors++; $display("FAIL redir_new_head got v=%0b pc=%h instr=%h want v=1 pc=2000 instr=%h", out_valid, out_pc, out_instr, exp_instr(62'h2000)); end
        tick;
        sample;
        checks++; if (out_pc !== 62'h2001) begin errors++; $display("FAIL redir_next got %h want 2001", out_pc); end
    endtask

    task automatic test_redirect_pop;
        reset_start(1'b1);
        for (int c = 1; c <= 3; c++) tick;
        tick;
        redirect_valid = 1'b1; redirect_pc = 62'h3000;
        sample;
        checks++; if (out_valid !== 1'b1 || out_pc !== RPC + 62'd1)
            begin errors++; $display("FAIL rpop_head got v=%0b pc=%h want v=1 pc=%h", out_valid, out_pc, RPC + 62'd1); end
        tick;
        redirect_valid = 1'b0;
        sample;
        checks++; if (out_valid !== 1'b0 || out_pc !== 62'd0 || out_instr !== 32'd0)
            begin errors++; $display("FAIL rpop_empty got v=%0b pc=%h instr=%h want v=0 pc=0 instr=0", out_valid, out_pc, out_instr); end
        checks++; if (imem_en !== 1'b1 || imem_a !== 32'hC000)
            begin errors++; $display("FAIL rpop_issue got en=%0b a=%h want en=1 a=c000", imem_en, imem_a); end
    endtask

    task automatic test_gate;
        reset_start(1'b1);
        tick;
        sample;
        checks++; if (imem_en !== 1'b1 || imem_a !== 32'h400)
            begin errors++; $display("FAIL gate_issue got en=%0b a=%h want en=1 a=400", imem_en, imem_a); end
        for (int c = 2; c <= 4; c++) begin
            tick;
            clk_en = 1'b0;
            sample;
            checks++; if (imem_en !== 1'b0 || out_valid !== 1'b0 || imem_a !== 32'h404)
                begin errors++; $display("FAIL gate_hold c%0d got en=%0b v=%0b a=%h want en=0 v=0 a=404", c, imem_en, out_valid, imem_a); end
        end
        tick;
        clk_en = 1'b1;
        sample;
        checks++; if (imem_en !== 1'b1 || imem_a !== 32'h404 || out_valid !== 1'b0)
            begin errors++; $display("FAIL gate_resume got en=%0b a=%h v=%0b want en=1 a=404 v=0", imem_en, imem_a, out_valid); end
        tick;
        sample;
        checks++; if (out_valid !== 1'b1 || out_pc !== RPC || out_instr !== exp_instr(RPC))
            begin errors++; $display("FAIL gate_push got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h", out_valid, out_pc, out_instr, RPC, exp_instr(RPC)); end
    endtask

    task automatic test_wrap;
        reset_start(1'b1);
        redirect_valid = 1'b1; redirect_pc = '1;
        sample;
        checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL wrap_boot_imem_en got %0b want 0", imem_en); end
        tick;
        redirect_valid = 1'b0;
        sample;
        checks++; if (imem_en !== 1'b1 || imem_a !== 32'hFFFF_FFFC)
            begin errors++; $display("FAIL wrap_top got en=%0b a=%h want en=1 a=fffffffc", imem_en, imem_a); end
        tick;
        sample;
        checks++; if (imem_a !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h want 0", imem_a); end
        tick;
        sample;
        checks++; if (out_pc !== 62'h3FFF_FFFF_FFFF_FFFF)
            begin errors++; $display("FAIL wrap_head_top got %h want 3fffffffffffffff", out_pc); end
        tick;
        sample;
        checks++; if (out_pc !== 62'd0) begin errors++; $display("FAIL wrap_head_zero got %h want 0", out_pc); end
    endtask

    task automatic test_midreset;
        reset_start(1'b0);
        for (int c = 1; c <= 5; c++) tick;
        sample;
`ifdef FETCH_PERF_EN
        checks++; if (perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL perf_pre got %0d want 0", perf_stall_cnt); end
`endif
        for (int c = 6; c <= 15; c++) tick;
        sample;
        checks++; if (out_valid !== 1'b1 || imem_en !== 1'b0)
            begin errors++; $display("FAIL mid_full got v=%0b en=%0b want v=1 en=0", out_valid, imem_en); end
`ifdef FETCH_PERF_EN
        checks++; if (perf_stall_cnt !== 32'd10) begin errors++; $display("FAIL perf_stall got %0d want 10", perf_stall_cnt); end
`endif
        tick;
        rst = 1'b0;
        sample;
        checks++; if (out_valid !== 1'b0 || imem_en !== 1'b0)
            begin errors++; $display("FAIL mid_rst_low got v=%0b en=%0b want v=0 en=0", out_valid, imem_en); end
        tick;
        rst = 1'b1;
        out_ready = 1'b1;
        sample;
        checks++; if (out_valid !== 1'b0 || imem_en !== 1'b0)
            begin errors++; $display("FAIL mid_boot got v=%0b en=%0b want v=0 en=0", out_valid, imem_en); end
`ifdef FETCH_PERF_EN
        checks++; if (perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL perf_reset got %0d want 0", perf_stall_cnt); end
`endif
        tick;
        sample;
        checks++; if (imem_en !== 1'b1 || imem_a !== 32'h400)
            begin errors++; $display("FAIL mid_restart got en=%0b a=%h want en=1 a=400", imem_en, imem_a); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_fill;
        test_redirect;
        test_redirect_pop;
        test_gate;
        test_wrap;
        test_midreset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
